// File: rtl/prga.sv
// ARC4 PRGA / decrypt stage: reads key-scheduled S and length-prefixed CT, writes length-prefixed PT.
// Optional plaintext printability check enabled by defining PRGA_KEYCHECK_EN.
module prga #(
  parameter int MSG_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic       key_valid
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT, DONE
  } state_e;

  localparam logic [8:0] MAX9 = 9'(MSG_MAX);

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, ct_q, ct_d;
  logic [7:0] len_next, pt_byte;

  // Length and keystream byte are taken straight off the read bus the cycle they become valid.
  assign len_next = ({1'b0, ct_rddata} > MAX9) ? MAX9[7:0] : ct_rddata;
  assign pt_byte  = ct_q ^ s_rddata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    len_d   = len_q;
    si_d    = si_q;
    sj_d    = sj_q;
    ct_d    = ct_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (en)                 state_d = RD_LEN;
        else if (state_q == DONE) state_d = IDLE;
      end
      RD_LEN: state_d = WR_LEN;
      WR_LEN: begin
        len_d   = len_next;
        i_d     = '0;
        j_d     = '0;
        k_d     = 8'd1;
        state_d = (len_next == 8'd0) ? DONE : RD_SI;
      end
      RD_SI: begin
        i_d     = i_q + 8'd1;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = WR_SI;
      end
      WR_SI: begin
        sj_d    = s_rddata;
        state_d = WR_SJ;
      end
      WR_SJ:  state_d = RD_PAD;
      RD_PAD: begin
        ct_d    = ct_rddata;
        state_d = WR_PT;
      end
      WR_PT: begin
        if (k_q == len_q) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy       = (state_q == IDLE) || (state_q == DONE);
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    unique case (state_q)
      WR_LEN: begin
        pt_wrdata = len_next;
        pt_wren   = 1'b1;
      end
      RD_SI:  s_addr = i_q + 8'd1;
      RD_SJ:  s_addr = j_q + s_rddata;
      WR_SI: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        ct_addr  = k_q;
      end
      RD_PAD: s_addr = si_q + sj_q;
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = pt_byte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PRGA_KEYCHECK_EN
  logic ok_q, ok_d, kv_q, kv_d, printable;

  assign printable = (pt_byte >= 8'h20) && (pt_byte <= 8'h7E);
  assign key_valid = kv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q <= 1'b0;
      kv_q <= 1'b0;
    end else begin
      ok_q <= ok_d;
      kv_q <= kv_d;
    end
  end

  // Verdict lands on the edge into DONE so it is already visible while rdy rises.
  always_comb begin
    ok_d = ok_q;
    kv_d = kv_q;
    if (rdy && en) begin
      ok_d = 1'b1;
      kv_d = 1'b0;
    end
    if (state_q == WR_LEN && len_next == 8'd0) kv_d = 1'b1;
    if (state_q == WR_PT) begin
      ok_d = ok_q & printable;
      if (k_q == len_q) kv_d = ok_q & printable;
    end
  end
`else
  assign key_valid = 1'b0;
`endif

endmodule

// File: tb/tb_prga.sv
// Directed bench for prga with behavioural S/CT/PT memories (1-cycle read latency).
module tb_prga;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic       rdy, s_wren, pt_wren, key_valid;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;

  logic [7:0] s_mem[256], ct_mem[256], pt_mem[256];
  logic [7:0] s_img[256], ct_img[256], ks[256], exp_pt[256];
  logic       load;
  int         pt_cnt, s_cnt;
  int         checks = 0, failures = 0;

`ifdef PRGA_KEYCHECK_EN
  localparam bit KC = 1'b1;
`else
  localparam bit KC = 1'b0;
`endif

  prga #(.MSG_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]  <= s_img[a];
        ct_mem[a] <= ct_img[a];
        pt_mem[a] <= 8'hEE;
      end
      pt_cnt <= 0;
      s_cnt  <= 0;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_cnt         <= s_cnt + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_cnt          <= pt_cnt + 1;
      end
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
  endtask

  task automatic clear_ct();
    for (int a = 0; a < 256; a++) ct_img[a] = 8'h00;
  endtask

  // Reference ARC4 key schedule for a 3-byte key.
  task automatic ksa(input logic [23:0] key);
    logic [7:0] j, t, kb;
    set_identity();
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      kb = 8'(key >> (8 * (2 - (a % 3))));
      j = j + s_img[a] + kb;
      t = s_img[a]; s_img[a] = s_img[j]; s_img[j] = t;
    end
  endtask

  task automatic gen_ks(input int n);
    logic [7:0] s[256];
    logic [7:0] i, j, t, p;
    for (int a = 0; a < 256; a++) s[a] = s_img[a];
    i = 8'd0; j = 8'd0;
    for (int m = 1; m <= n; m++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      p = s[i] + s[j];
      ks[m] = s[p];
    end
  endtask

  task automatic run_prga(input int len, output int cyc);
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    check_eq("rdy_fall", rdy, 1'b0);
    cyc = 1;
    while (!rdy && cyc < 8 * len + 8) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rdy_latency", rdy, 1'b1);
  endtask

  task automatic check_pt(input string tag, input int len);
    for (int m = 0; m <= len; m++)
      check_eq($sformatf("%s_pt%0d", tag, m), pt_mem[m], exp_pt[m]);
    check_eq($sformatf("%s_untouched", tag), pt_mem[(len + 1) % 256], 8'hEE);
    check_eq($sformatf("%s_ptcnt", tag), pt_cnt, len + 1);
  endtask

  initial begin
    int    cyc, n;
    bit    pr;
    string msg;
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    set_identity(); clear_ct();
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", rdy, 1'b1);
    check_eq("rst_wren", {s_wren, pt_wren}, 2'b00);
    check_eq("rst_addr", {s_addr, ct_addr, pt_addr}, 24'h0);
    check_eq("rst_wrdata", {s_wrdata, pt_wrdata}, 16'h0);
    check_eq("rst_kv", key_valid, 1'b0);
    rst_n = 1'b1;

    // Identity S, three zero CT bytes: keystream 02,05,07 with the i=j=1 self-swap.
    set_identity(); clear_ct(); ct_img[0] = 8'd3;
    load_mem();
    run_prga(3, cyc);
    exp_pt[0] = 8'h03; exp_pt[1] = 8'h02; exp_pt[2] = 8'h05; exp_pt[3] = 8'h07;
    check_pt("ident", 3);
    check_eq("ident_s1", s_mem[1], 8'd1);
    check_eq("ident_s2", s_mem[2], 8'd3);
    check_eq("ident_s3", s_mem[3], 8'd5);
    check_eq("ident_s5", s_mem[5], 8'd2);
    check_eq("ident_kv", key_valid, 1'b0);

    // Empty message.
    set_identity(); clear_ct();
    load_mem();
    run_prga(0, cyc);
    exp_pt[0] = 8'h00;
    check_pt("len0", 0);
    check_eq("len0_swr", s_cnt, 0);
    check_eq("len0_kv", key_valid, KC);

    // Published vector: key "Key", ciphertext of "Plaintext".
    ksa(24'h4B6579); clear_ct();
    ct_img[0] = 8'd9;
    ct_img[1] = 8'hBB; ct_img[2] = 8'hF3; ct_img[3] = 8'h16; ct_img[4] = 8'hE8;
    ct_img[5] = 8'hD9; ct_img[6] = 8'h40; ct_img[7] = 8'hAF; ct_img[8] = 8'h0A;
    ct_img[9] = 8'hD3;
    msg = "Plaintext";
    exp_pt[0] = 8'd9;
    for (int m = 1; m <= 9; m++) exp_pt[m] = msg[m-1];
    load_mem();
    run_prga(9, cyc);
    check_pt("keyvec", 9);
    check_eq("keyvec_kv", key_valid, KC);

    // Key 00_01_55 on a printable message.
    msg = "Attack at dawn";
    ksa(24'h000155); clear_ct(); gen_ks(14);
    ct_img[0] = 8'd14; exp_pt[0] = 8'd14;
    for (int m = 1; m <= 14; m++) begin
      exp_pt[m] = msg[m-1];
      ct_img[m] = exp_pt[m] ^ ks[m];
    end
    load_mem();
    run_prga(14, cyc);
    check_pt("k155", 14);
    check_eq("k155_kv", key_valid, KC);

    // Wrong key 00_00_00 on the same CT.
    ksa(24'h000000); gen_ks(14);
    pr = 1'b1;
    for (int m = 1; m <= 14; m++) begin
      exp_pt[m] = ct_img[m] ^ ks[m];
      if (exp_pt[m] < 8'h20 || exp_pt[m] > 8'h7E) pr = 1'b0;
    end
    load_mem();
    run_prga(14, cyc);
    check_pt("wrongkey", 14);
    check_eq("wrongkey_kv", key_valid, KC & pr);

    // Last byte decodes to 0x7F, then to 0x7E (identity keystream 02,05,07).
    set_identity(); clear_ct();
    ct_img[0] = 8'd3; ct_img[1] = 8'h43; ct_img[2] = 8'h47; ct_img[3] = 8'h78;
    load_mem();
    run_prga(3, cyc);
    check_eq("b7f_pt3", pt_mem[3], 8'h7F);
    check_eq("b7f_kv", key_valid, 1'b0);
    ct_img[3] = 8'h79;
    load_mem();
    run_prga(3, cyc);
    check_eq("b7e_pt3", pt_mem[3], 8'h7E);
    check_eq("b7e_kv", key_valid, KC);

    // en held three cycles plus a stray pulse while busy: a single run.
    load_mem();
    @(negedge clk) en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk) en = 1'b0;
    n = 0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_rdy", rdy, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("hold_ptcnt", pt_cnt, 4);
    check_eq("hold_rdy_stays", rdy, 1'b1);

    // Reset during byte 5 of a 20-byte run, then a clean rerun.
    set_identity(); clear_ct();
    ct_img[0] = 8'd20;
    for (int m = 1; m <= 20; m++) ct_img[m] = 8'(m * 7 + 3);
    gen_ks(20);
    exp_pt[0] = 8'd20;
    for (int m = 1; m <= 20; m++) exp_pt[m] = ct_img[m] ^ ks[m];
    load_mem();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    n = 0;
    while (!(pt_wren && pt_addr == 8'd4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_reach_b4", pt_wren && pt_addr == 8'd4, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rdy", rdy, 1'b1);
    check_eq("mid_wren", {s_wren, pt_wren}, 2'b00);
    repeat (3) @(negedge clk);
    check_eq("mid_ptcnt", pt_cnt, 5);
    load_mem();
    run_prga(20, cyc);
    check_pt("rerun", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prga.md
Name: prga

Overview:
- ARC4 pseudo-random generation / decrypt stage.
- Sits directly downstream of the KSA stage in the task3 datapath. Consumes the key-scheduled S array left in S memory and the length-prefixed ciphertext in CT memory.
- Writes the length-prefixed plaintext to PT memory.
- Started by the top-level controller via an en/rdy handshake once KSA reports rdy.

Parameters:
- MSG_MAX, 255, largest message length accepted; ct[0] values above it are clamped to MSG_MAX.

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data, valid the cycle after s_addr is presented
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  8  CT memory address
- ct_rddata  in  8  CT read data, valid the cycle after ct_addr is presented
- pt_addr  out  8  PT memory address
- pt_wrdata  out  8  PT write data
- pt_wren  out  1  PT write enable
- key_valid  out  1  plaintext-printable flag; see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; rdy=1; all wren=0; all addr/wrdata=0; key_valid=0; i=j=k=0.
- Reset applies mid-operation: abort at once with no further writes. S and PT contents are left as they were.
- Handshake:
  - en is accepted only on a cycle where rdy=1. rdy falls the next cycle.
  - en while rdy=0 is ignored.
  - rdy rises exactly once on completion and stays high until the next accepted en.
- Memories are synchronous with 1-cycle read latency. At most one write per memory per cycle. A write never coincides with a read on the same port.
- States:
  - IDLE: waits for en.
  - RD_LEN: read ct[0]; on data valid, latch len = min(ct[0], MSG_MAX).
  - WR_LEN: write pt[0] = len; set i=j=0, k=1. If len=0, go to DONE.
  - RD_SI: i=(i+1) mod 256; read S[i]; latch si.
  - RD_SJ: j=(j+si) mod 256; read S[j]; latch sj.
  - WR_SI: write S[i]=sj.
  - WR_SJ: write S[j]=si; read ct[k] and latch ct byte.
  - RD_PAD: read S[(si+sj) mod 256]; latch pad.
  - WR_PT: write pt[k] = ct[k] XOR pad. If k==len go to DONE, else k=k+1 and go to RD_SI.
  - DONE: rdy=1 and go to IDLE; key_valid is updated on this cycle.
- Arithmetic: all i/j/index sums are 8-bit, wrapping mod 256. i wraps 255→0 for messages longer than 255 key bytes (not reachable with MSG_MAX=255, but the logic must not depend on that).
- i==j: both swap writes target the same address. The final value is S[i]=si, i.e. unchanged, matching the reference algorithm. Pad index = 2·si mod 256.
- Latency:
  - Must not exceed 8·len + 8 cycles from accepted en to rdy=1.
  - The state list above gives 6·len + 4 and is the expected schedule.
- S memory is left in its post-PRGA permuted state. PT bytes above index len are untouched.

Optional Feature:
- Macro: PRGA_KEYCHECK_EN.
- Defined:
  - key_valid is cleared on accepted en.
  - At DONE it is set to 1 iff every pt[k], k=1..len, lies in 0x20..0x7E inclusive. len=0 gives 1.
  - The check is accumulated per byte in WR_PT with no extra cycles.
  - Used by the cracking stage to accept or reject a key.
- Undefined: key_valid is tied to 0 and no checking logic is synthesised; timing is otherwise identical.

Test Plan:
- S preloaded from KSA with key 00_01_55; CT = test1.memh; en pulse → PT[0..ct[0]] equals the software ARC4 model byte-for-byte; rdy high within 8·ct[0]+8 cycles; with PRGA_KEYCHECK_EN, key_valid=1.
- ct[0]=0 → exactly one PT write (pt[0]=0x00); no S writes; rdy back within 8 cycles.
- S = identity (S[x]=x), ct[0]=3, ct[1..3]=0 → pt = 03,02,05,07 (a software check of the keystream for identity S). The i=j=1 self-swap occurs on byte 1 and leaves S[1]=1.
- en held high for 3 cycles, and a second en pulse while busy → only one run; PT write count = len+1.
- rst_n low for one cycle in the middle of byte 5 of a 20-byte run → rdy=1 and all wren=0 on the next cycle; a fresh en after reloading S reproduces the correct full PT.
- PRGA_KEYCHECK_EN, wrong key (00_00_00) on test1 CT → key_valid=0. A message whose last byte decodes to 0x7F → key_valid=0; one whose last byte decodes to 0x7E → key_valid=1.
